ib_read_contr_b3: RTL

- Read-side controller for the block-3 input buffer: 16 single-port RAM lanes of 14 × 32-bit words each.
- Fetches each lane's words in address order and serialises them MSB-first into one bit per cycle per lane, with lane-to-lane skew of 1 cycle. This feeds the block-3 binarised compute array.
- It is the counterpart of the block-3 input-buffer write controller: bit order, word order and lane skew mirror the write side, so the bit stream reproduces the write-side input stream.

---
 rtl/ib_read_contr_b3.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/ib_read_contr_b3.sv
// Read-side controller for the block-3 input buffer: fetches 16 RAM lanes word by word
// and serialises each word MSB-first, with lane i trailing lane 0 by exactly i cycles.
module ib_read_contr_b3 #(
    parameter int NUM_LANES = 16,
    parameter int WORD_W    = 32,
    parameter int NUM_WORDS = 14,
    parameter int ADDR_W    = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    output logic [NUM_LANES-1:0]          rd_en,
    output logic [NUM_LANES*ADDR_W-1:0]   rd_addr,
    input  logic [NUM_LANES*WORD_W-1:0]   rd_data,
    output logic [NUM_LANES-1:0]          bout,
    output logic [NUM_LANES-1:0]          bout_val,
    output logic                          busy,
    output logic                          done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_SHIFT,
        S_FIN
    } state_t;

    localparam logic [4:0]        LAST_BIT     = 5'(WORD_W - 1);
    localparam logic [4:0]        PREFETCH_BIT = 5'(WORD_W - 3);
    localparam logic [4:0]        DRAIN_LAST   = 5'(NUM_LANES - 2);
    localparam logic [ADDR_W-1:0] LAST_WORD    = ADDR_W'(NUM_WORDS - 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [4:0]          r_bit_cnt;
    logic [4:0]          w_bit_cnt_nxt;
    logic [ADDR_W-1:0]   r_word_cnt;
    logic [ADDR_W-1:0]   w_word_cnt_nxt;
    logic                r_busy;
    logic                w_busy_nxt;
    logic                r_done;
    logic                w_done_nxt;

    logic                w_rd_en0_nxt;
    logic [ADDR_W-1:0]   w_addr0_nxt;
    logic                w_val0_nxt;

    // Skew lines: index 0 is lane 0, index i is lane 0 delayed by i cycles.
    logic [NUM_LANES-1:0] r_rd_en;
    logic [NUM_LANES-1:0] r_ld;
    logic [NUM_LANES-1:0] r_val;
    logic [ADDR_W-1:0]    r_addr [NUM_LANES];
    logic [WORD_W-1:0]    r_sreg [NUM_LANES];
    logic [NUM_LANES-1:0] w_bout;

    // Lane-0 sequencer. r_word_cnt is the word currently being emitted; the next word
    // is requested two bits before the current one runs out so the stream never gaps.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path infers a latch.
        w_state_nxt    = r_state;
        w_bit_cnt_nxt  = r_bit_cnt;
        w_word_cnt_nxt = r_word_cnt;
        w_busy_nxt     = r_busy;
        w_done_nxt     = r_done;
        w_rd_en0_nxt   = 1'b0;
        w_addr0_nxt    = r_addr[0];
        w_val0_nxt     = r_val[0];

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt    = S_FETCH;
                    w_rd_en0_nxt   = 1'b1;
                    w_addr0_nxt    = '0;
                    w_word_cnt_nxt = '0;
                    w_bit_cnt_nxt  = '0;
                    w_busy_nxt     = 1'b1;
                    w_done_nxt     = 1'b0;
                end
            end

            S_FETCH: begin
                if (r_ld[0]) begin
                    w_state_nxt   = S_SHIFT;
                    w_val0_nxt    = 1'b1;
                    w_bit_cnt_nxt = '0;
                end
            end

            S_SHIFT: begin
                w_bit_cnt_nxt = r_bit_cnt + 5'd1;
                if (r_bit_cnt == PREFETCH_BIT && r_word_cnt != LAST_WORD) begin
                    w_rd_en0_nxt = 1'b1;
                    w_addr0_nxt  = r_word_cnt + ADDR_W'(1);
                end
                if (r_bit_cnt == LAST_BIT) begin
                    if (r_word_cnt == LAST_WORD) begin
                        w_state_nxt   = S_FIN;
                        w_val0_nxt    = 1'b0;
                        w_bit_cnt_nxt = '0;
                    end else begin
                        w_word_cnt_nxt = r_word_cnt + ADDR_W'(1);
                    end
                end
            end

            S_FIN: begin
                // Lanes 1..NUM_LANES-1 are still draining through the skew lines.
                if (r_bit_cnt == DRAIN_LAST) begin
                    w_state_nxt = S_IDLE;
                    w_busy_nxt  = 1'b0;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_bit_cnt_nxt = r_bit_cnt + 5'd1;
                end
            end

            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_bit_cnt  <= '0;
            r_word_cnt <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_bit_cnt  <= w_bit_cnt_nxt;
            r_word_cnt <= w_word_cnt_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_en <= '0;
            r_ld    <= '0;
            r_val   <= '0;
            // NOTE: these arrays are ordinary flops, not RAM, so they are reset like any register.
            for (int i = 0; i < NUM_LANES; i++) begin
                r_addr[i] <= '0;
            end
        end else begin
            r_rd_en[0] <= w_rd_en0_nxt;
            r_val[0]   <= w_val0_nxt;
            r_addr[0]  <= w_addr0_nxt;
            // NOTE: non-blocking assignment makes each stage take its neighbour's old value.
            for (int i = 1; i < NUM_LANES; i++) begin
                r_rd_en[i] <= r_rd_en[i-1];
                r_val[i]   <= r_val[i-1];
                r_addr[i]  <= r_addr[i-1];
            end
            r_ld <= r_rd_en;
        end
    end

    // A load coincides with the last bit of the previous word, so load wins over shift.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                r_sreg[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_LANES; i++) begin
                if (r_ld[i]) begin
                    r_sreg[i] <= rd_data[i*WORD_W +: WORD_W];
                end else if (r_val[i]) begin
                    r_sreg[i] <= {r_sreg[i][WORD_W-2:0], 1'b0};
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        assign rd_addr[g*ADDR_W +: ADDR_W] = r_addr[g];
        assign w_bout[g]                   = r_sreg[g][WORD_W-1] & r_val[g];
    end

    assign rd_en    = r_rd_en;
    assign bout     = w_bout;
    assign bout_val = r_val;
    assign busy     = r_busy;
    assign done     = r_done;

endmodule
